window_5x5: RTL and testbench
=============================

WINDOW_5X5 -- requirements
Module: window_5x5

Interface
REQ-001 Parameter IMG_WIDTH, default 640: pixels per row; SHALL be >= 5.
REQ-002 Parameter IMG_HEIGHT, default 480: rows per frame; SHALL be >= 5.
REQ-003 Parameter DATA_WIDTH, default 24: bits per pixel, packed {red, green, blue}.
REQ-004 clk  input  1: single clock; all logic SHALL be on the rising edge.
REQ-005 rst  input  1: reset, asynchronous and active-low.
REQ-006 pixel_i  input  DATA_WIDTH: incoming pixel, raster order.
REQ-007 done_i  input  1: pixel_i valid this cycle; may deassert for any number of cycles (stall).
REQ-008 window_o  output  25*DATA_WIDTH: 5x5 window; slot k = 5*r+c (r = row 0 oldest..4 newest, c = col 0 oldest..4 newest) at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 done_o  output  1: window_o valid, one-cycle pulse per window.
REQ-010 frame_done_o  output  1: one-cycle pulse with the last window of a frame.

Function
REQ-011 4 line buffers, each IMG_WIDTH deep, chained; read/write addressed by a shared column counter col (0..IMG_WIDTH-1).
REQ-012 On each cycle with done_i=1: write pixel_i into line 0 at col; move each line n's old value at col into line n+1; shift the 5 incoming column values (4 line outputs + pixel_i) into the 5x5 register window.
REQ-013 done_i=0: no counter, memory or window change; done_o=0.
REQ-014 Counter col increments per accepted pixel; wraps to 0 after IMG_WIDTH-1 and increments row (0..IMG_HEIGHT-1).
REQ-015 Counter row wraps to 0 after IMG_HEIGHT-1; the next accepted pixel starts a new frame with no reset required.
REQ-016 Valid windows only (no padding): done_o SHALL pulse the cycle after an accepted pixel with row >= 4 and col >= 4.
REQ-017 Latency: 1 cycle from the accepting done_i edge to done_o; window_o is registered and holds its value until the next accepted pixel.
REQ-018 Windows per frame SHALL be exactly (IMG_WIDTH-4)*(IMG_HEIGHT-4).
REQ-019 The window SHALL NOT straddle rows: at col 0..3, done_o=0 even though the window still contains columns from the previous row.
REQ-020 frame_done_o SHALL pulse together with done_o for the pixel at row=IMG_HEIGHT-1, col=IMG_WIDTH-1.
REQ-021 The first 4 rows of every frame prime the line buffers; stale data from the previous frame SHALL NOT be emitted, which REQ-016 guarantees.
REQ-022 Back-to-back done_i (1 pixel/cycle) SHALL be sustained with no bubbles.

Reset
REQ-023 rst=0 SHALL asynchronously clear row, col, the window registers, done_o and frame_done_o to 0.
REQ-024 Line-buffer memory contents are not reset; the design SHALL not depend on them (REQ-021).
REQ-025 Reset asserted mid-frame SHALL abort the frame; the first pixel after release is row 0, col 0.

Structure
REQ-026 A shared package SHALL hold the window size constant (5), the slot-index function, and default IMG_WIDTH/IMG_HEIGHT/DATA_WIDTH.
REQ-027 One sub-module, line_buffer (single-port read-before-write RAM, depth IMG_WIDTH, width DATA_WIDTH), SHALL be instantiated 4 times.
REQ-028 Output interface SHALL connect directly to the downstream median sorter (window_o -> window input, done_o -> done_i).

Verification (IMG_WIDTH=8, IMG_HEIGHT=6 unless stated)
REQ-029 Feed pixel value = 16*row+col back-to-back -> 8 done_o pulses; the first occurs 1 cycle after pixel (4,4), with slot 0 = 0x00 and slot 24 = 0x44.
REQ-030 Same frame with done_i low on every other cycle -> identical window sequence, each done_o 1 cycle after its accepting edge.
REQ-031 At pixels (4,0)..(4,3) -> done_o=0; at (5,4) -> slot 0 = 0x10 and slot 24 = 0x54.
REQ-032 Two frames back-to-back -> frame_done_o pulses exactly twice, at (5,7) of each frame; second frame windows free of first-frame data.
REQ-033 Assert rst at pixel (4,5), release, send a full frame -> outputs 0 during reset; then exactly 8 windows, first at (4,4).
REQ-034 Median_tb BMP flow through window_5x5 -> median: output count = (W-4)*(H-4) per frame.

Source files
------------

// File: rtl/window_5x5_pkg.sv
// Shared constants for the 5x5 sliding-window block.
package window_5x5_pkg;
  localparam int WIN            = 5;
  localparam int NUM_SLOTS      = WIN * WIN;
  localparam int NUM_LINES      = WIN - 1;
  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;
  localparam int DEF_DATA_WIDTH = 24;

  // Flat slot index of window element (row r, col c); row 0 / col 0 are the oldest.
  function automatic int slot_idx(input int r, input int c);
    return WIN * r + c;
  endfunction
endpackage

// File: rtl/window_5x5_if.sv
// Pixel-in / window-out bus; the window side feeds the median sorter directly.
interface window_5x5_if
  import window_5x5_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0]           pixel_i;
  logic                            done_i;
  logic [NUM_SLOTS*DATA_WIDTH-1:0] window_o;
  logic                            done_o;
  logic                            frame_done_o;

  modport master (output pixel_i, done_i, input window_o, done_o, frame_done_o);
  modport slave  (input pixel_i, done_i, output window_o, done_o, frame_done_o);
endinterface

// File: rtl/window_5x5_line_buffer.sv
// One image row of storage: async read, write on clock, so a same-cycle
// access returns the old value (read-before-write). Contents are never reset.
module line_buffer #(
  parameter int DEPTH      = 640,
  parameter int DATA_WIDTH = 24,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  // Store the incoming value over the one just read out.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end
endmodule

// File: rtl/window_5x5.sv
// 5x5 sliding window over a raster pixel stream. Four chained line buffers
// supply the four previous rows of the current column; the newest column is
// shifted into a register window. Only fully in-frame windows are flagged.
module window_5x5
  import window_5x5_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  window_5x5_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_EDGE = CW'(NUM_LINES);
  localparam logic [RW-1:0] ROW_EDGE = RW'(NUM_LINES);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_done;
  logic          r_frame_done;
  // [row][col][pixel]; packed so element (r,c) lands at slot 5r+c of the flat output.
  logic [WIN-1:0][WIN-1:0][DATA_WIDTH-1:0] r_win;

  logic                                w_acc;
  logic [NUM_LINES-1:0][DATA_WIDTH-1:0] w_lb_wdata;
  logic [NUM_LINES-1:0][DATA_WIDTH-1:0] w_lb_rdata;
  logic [WIN-1:0][DATA_WIDTH-1:0]       w_col;

  assign w_acc = bus.done_i;

  // Line n holds the row n+1 above the current one; line 0 is fed by the live pixel.
  for (genvar n = 0; n < NUM_LINES; n++) begin : g_lb
    if (n == 0) begin : g_head
      assign w_lb_wdata[n] = bus.pixel_i;
    end else begin : g_chain
      assign w_lb_wdata[n] = w_lb_rdata[n-1];
    end
    line_buffer #(
      .DEPTH      (IMG_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .AW         (CW)
    ) u_lb (
      .clk     (clk),
      .i_we    (w_acc),
      .i_addr  (r_col),
      .i_wdata (w_lb_wdata[n]),
      .o_rdata (w_lb_rdata[n])
    );
    // Window row 0 is the oldest, i.e. the deepest line buffer.
    assign w_col[NUM_LINES-1-n] = w_lb_rdata[n];
  end
  assign w_col[WIN-1] = bus.pixel_i;

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Shift the new column in at col 4; col 0 drops out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win <= '0;
    end else if (w_acc) begin
      for (int r = 0; r < WIN; r++) r_win[r] <= {w_col[r], r_win[r][WIN-1:1]};
    end
  end

  // Flag windows lying fully inside the frame; earlier columns still hold the previous row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_done       <= w_acc && (r_row >= ROW_EDGE) && (r_col >= COL_EDGE);
      r_frame_done <= w_acc && (r_row == ROW_LAST) && (r_col == COL_LAST);
    end
  end

  assign bus.window_o     = r_win;
  assign bus.done_o       = r_done;
  assign bus.frame_done_o = r_frame_done;
endmodule

// File: tb/tb_window_5x5.sv
// Randomized scoreboard bench for window_5x5 on an 8x6 image.
module tb_window_5x5;
  import window_5x5_pkg::*;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int DW   = 24;
  localparam int NWIN = (W - 4) * (H - 4);

  typedef struct {
    logic [NUM_SLOTS*DW-1:0] win;
    bit                      fd;
    longint                  cyc;
  } exp_t;

  logic   clk;
  logic   rst;
  longint cyc;
  int     checks;
  int     failures;
  int     win_seen;
  int     fd_seen;
  int     fwin;
  bit     directed;

  exp_t          q[$];
  logic [DW-1:0] img [H][W];
  int            m_row;
  int            m_col;

  window_5x5_if #(.DATA_WIDTH(DW)) bus ();

  window_5x5 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [599:0] act, input logic [599:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: keep the current frame as a 2D image and cut windows out of it.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_row = 0;
      m_col = 0;
      q.delete();
    end else if (bus.done_i) begin
      img[m_row][m_col] = bus.pixel_i;
      if (m_row >= 4 && m_col >= 4) begin
        exp_t e;
        for (int r = 0; r < WIN; r++)
          for (int c = 0; c < WIN; c++)
            e.win[slot_idx(r, c)*DW +: DW] = img[m_row-4+r][m_col-4+c];
        e.fd  = (m_row == H - 1) && (m_col == W - 1);
        e.cyc = cyc;
        q.push_back(e);
      end
      m_col++;
      if (m_col == W) begin
        m_col = 0;
        m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end
    end
  end

  // Monitor: every presented window must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst) begin
      fwin = 0;
    end else if (bus.done_o) begin
      win_seen++;
      if (bus.frame_done_o) fd_seen++;
      if (q.size() == 0) begin
        chk("unexpected_window", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("window", bus.window_o, e.win);
        chk("frame_done", bus.frame_done_o, e.fd);
        chk("latency", cyc, e.cyc + 1);
        if (directed && fwin == 0) begin
          chk("first_slot0", bus.window_o[slot_idx(0, 0)*DW +: DW], 24'h00);
          chk("first_slot24", bus.window_o[slot_idx(4, 4)*DW +: DW], 24'h44);
        end
        if (directed && fwin == 4) begin
          chk("row5_slot0", bus.window_o[slot_idx(0, 0)*DW +: DW], 24'h10);
          chk("row5_slot24", bus.window_o[slot_idx(4, 4)*DW +: DW], 24'h54);
        end
      end
      fwin = bus.frame_done_o ? 0 : fwin + 1;
    end else if (bus.frame_done_o) begin
      chk("frame_done_without_done", 1, 0);
    end
  end

  task automatic idle(input int n);
    bus.done_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: 16*row+col back-to-back, 1: same with every other cycle idle,
  // 2: random pixels with random stalls, 3: random pixels back-to-back.
  // Sends pixels up to (stop_r, stop_c) inclusive.
  task automatic send_frame(input int mode, input int stop_r = H - 1, input int stop_c = W - 1);
    directed = (mode < 2);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r > stop_r || (r == stop_r && c > stop_c)) return;
        if (mode == 1) idle(1);
        if (mode == 2 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        bus.pixel_i = (mode < 2) ? DW'(16 * r + c) : DW'($urandom);
        bus.done_i  = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    bus.done_i = 1'b0;
  endtask

  task automatic check_frames(input string name, input int w0, input int f0, input int nframes);
    idle(3);
    chk({name, "_windows"}, win_seen - w0, nframes * NWIN);
    chk({name, "_frame_done"}, fd_seen - f0, nframes);
  endtask

  initial begin
    int w0, f0;
    cyc = 0; checks = 0; failures = 0; win_seen = 0; fd_seen = 0; fwin = 0; directed = 0;
    rst = 1'b0;
    bus.pixel_i = '0;
    bus.done_i  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_done", bus.done_o, 0);
    chk("reset_frame_done", bus.frame_done_o, 0);
    chk("reset_window", bus.window_o, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    w0 = win_seen; f0 = fd_seen;
    send_frame(0);
    check_frames("ramp", w0, f0, 1);

    w0 = win_seen; f0 = fd_seen;
    send_frame(1);
    check_frames("stall_alt", w0, f0, 1);

    w0 = win_seen; f0 = fd_seen;
    send_frame(3);
    send_frame(3);
    check_frames("two_frames", w0, f0, 2);

    w0 = win_seen; f0 = fd_seen;
    send_frame(2);
    check_frames("rand_stall", w0, f0, 1);

    // Abort a frame right after pixel (4,5) is accepted.
    send_frame(0, 4, 5);
    rst = 1'b0;
    bus.done_i  = 1'b1;
    bus.pixel_i = DW'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_done", bus.done_o, 0);
      chk("abort_frame_done", bus.frame_done_o, 0);
      chk("abort_window", bus.window_o, 0);
    end
    @(posedge clk);
    #1;
    bus.done_i = 1'b0;
    rst = 1'b1;
    idle(1);
    w0 = win_seen; f0 = fd_seen;
    send_frame(0);
    check_frames("after_abort", w0, f0, 1);

    w0 = win_seen; f0 = fd_seen;
    send_frame(2);
    send_frame(3);
    check_frames("mixed", w0, f0, 2);

    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
